player_missile_ctrl: RTL and testbench

- Parametrised successor to the fixed player sprite block.
- Owns the player cannon's horizontal position and moves it from left/right buttons once per frame, with clamping at the screen edges.
- Adds a single-missile launch/flight/cooldown state machine.
- Generates pixel-region and pixel-colour outputs for both the cannon and the missile. The VGA colour mux consumes these; collision logic reads the registered positions.

---
 rtl/player_missile_ctrl.sv | 153 +++++++++++++++
 tb/tb_player_missile_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/player_missile_ctrl.sv
// Player cannon position/rendering plus a single-missile launch, flight and cooldown controller.
// Positions and state are registered; pixel region/colour outputs are combinational from them.
module player_missile_ctrl #(
  parameter int unsigned SCREEN_W        = 640,
  parameter int unsigned SPR_W           = 30,
  parameter int unsigned SPR_H           = 20,
  parameter int unsigned TIP_H           = 4,
  parameter int unsigned PLAYER_ROW      = 430,
  parameter int unsigned STEP            = 4,
  parameter int unsigned MISSILE_H       = 8,
  parameter int unsigned MISSILE_SPEED   = 6,
  parameter int unsigned COOLDOWN_FRAMES = 10,
  parameter logic [3:0]  COLOR           = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] pixel_row,
  input  logic [11:0] pixel_column,
  input  logic        frame_tick,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_fire,
  input  logic        missile_hit,
  output logic [11:0] player_col,
  output logic [11:0] missile_row,
  output logic [11:0] missile_col,
  output logic        missile_busy,
  output logic        player_active,
  output logic [3:0]  player_output,
  output logic        missile_active,
  output logic [3:0]  missile_output
);

  localparam int unsigned MAX_COL = SCREEN_W - SPR_W - 1;
  localparam int unsigned CNT_W   = $clog2(COOLDOWN_FRAMES + 2);

  localparam logic [11:0]      HOME_COL   = 12'((SCREEN_W - SPR_W) / 2);
  localparam logic [11:0]      LAUNCH_ROW = 12'(PLAYER_ROW - MISSILE_H);
  localparam logic [11:0]      STEP_12    = 12'(STEP);
  localparam logic [11:0]      SPEED_12   = 12'(MISSILE_SPEED);
  localparam logic [12:0]      MAX_COL_13 = 13'(MAX_COL);
  localparam logic [12:0]      ROW_TOP    = 13'(PLAYER_ROW + 1);
  localparam logic [12:0]      ROW_BOT    = 13'(PLAYER_ROW + SPR_H);
  localparam logic [12:0]      TIP_BOT    = 13'(PLAYER_ROW + TIP_H);
  localparam logic [CNT_W-1:0] COOL_LOAD  = CNT_W'(COOLDOWN_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLIGHT   = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  state_t           state;
  logic             fire_q;
  logic             fire_pending;
  logic [CNT_W-1:0] cool_cnt;
  logic             fire_edge;
  logic [12:0]      col_right;

  assign fire_edge = btn_fire & ~fire_q;
  assign col_right = {1'b0, player_col} + 13'(STEP);

  // Cannon movement once per frame, clamped to the visible width
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      player_col <= HOME_COL;
    end else if (frame_tick) begin
      if (btn_left && !btn_right) begin
        player_col <= (player_col < STEP_12) ? 12'd0 : player_col - STEP_12;
      end else if (btn_right && !btn_left) begin
        player_col <= (col_right > MAX_COL_13) ? 12'(MAX_COL) : col_right[11:0];
      end
    end
  end

  // Missile state machine; a hit kills the missile even on a frame tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      fire_q       <= 1'b0;
      fire_pending <= 1'b0;
      cool_cnt     <= '0;
      missile_row  <= 12'd0;
      missile_col  <= 12'd0;
      missile_busy <= 1'b0;
    end else begin
      fire_q <= btn_fire;
      case (state)
        IDLE: begin
          if (frame_tick && fire_pending) begin
            state        <= FLIGHT;
            missile_busy <= 1'b1;
            missile_col  <= player_col + 12'(SPR_W / 2);
            missile_row  <= LAUNCH_ROW;
            fire_pending <= 1'b0;
          end else if (fire_edge) begin
            fire_pending <= 1'b1;
          end
        end
        FLIGHT: begin
          if (missile_hit || (frame_tick && (missile_row < SPEED_12))) begin
            state        <= COOLDOWN;
            missile_busy <= 1'b0;
            cool_cnt     <= COOL_LOAD;
          end else if (frame_tick) begin
            missile_row <= missile_row - SPEED_12;
          end
        end
        COOLDOWN: begin
          if (frame_tick) begin
            if (cool_cnt <= CNT_ONE) begin
              state    <= IDLE;
              cool_cnt <= '0;
            end else begin
              cool_cnt <= cool_cnt - CNT_ONE;
            end
          end
        end
        default: begin
          state        <= IDLE;
          missile_busy <= 1'b0;
        end
      endcase
    end
  end

  logic [12:0] prow;
  logic [12:0] pcol;
  logic [12:0] pc;
  logic [12:0] mr;
  logic [12:0] mc;
  logic        tip_row;
  logic        tip_col;

  assign prow = {1'b0, pixel_row};
  assign pcol = {1'b0, pixel_column};
  assign pc   = {1'b0, player_col};
  assign mr   = {1'b0, missile_row};
  assign mc   = {1'b0, missile_col};

  // Cannon: full-width body with a 2-pixel barrel in the top TIP_H rows
  assign player_active = (prow >= ROW_TOP) && (prow <= ROW_BOT) &&
                         (pcol > pc) && (pcol <= pc + 13'(SPR_W));
  assign tip_row       = prow <= TIP_BOT;
  assign tip_col       = (pcol == pc + 13'(SPR_W / 2)) || (pcol == pc + 13'(SPR_W / 2 + 1));
  assign player_output = (player_active && (!tip_row || tip_col)) ? COLOR : 4'd0;

  assign missile_active = missile_busy && (prow >= mr) && (prow <= mr + 13'(MISSILE_H - 1)) &&
                          (pcol >= mc) && (pcol <= mc + 13'd1);
  assign missile_output = missile_active ? COLOR : 4'd0;

endmodule

// File: tb/tb_player_missile_ctrl.sv
// Self-checking bench for player_missile_ctrl: directed scenarios plus randomized
// stimulus against a frame-level behavioural model of cannon and missile.
module tb_player_missile_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] pixel_row = 12'd0;
  logic [11:0] pixel_column = 12'd0;
  logic        frame_tick = 1'b0;
  logic        btn_left = 1'b0;
  logic        btn_right = 1'b0;
  logic        btn_fire = 1'b0;
  logic        missile_hit = 1'b0;
  logic [11:0] player_col;
  logic [11:0] missile_row;
  logic [11:0] missile_col;
  logic        missile_busy;
  logic        player_active;
  logic [3:0]  player_output;
  logic        missile_active;
  logic [3:0]  missile_output;

  int checks = 0;
  int failures = 0;

  // Reference model: phase 0 = idle, 1 = missile flying, 2 = cooling down
  int m_col, m_mrow, m_mcol, m_phase, m_cool_ticks;
  bit m_pend, m_prev;

  player_missile_ctrl dut (
    .clk(clk), .rst(rst), .pixel_row(pixel_row), .pixel_column(pixel_column),
    .frame_tick(frame_tick), .btn_left(btn_left), .btn_right(btn_right),
    .btn_fire(btn_fire), .missile_hit(missile_hit), .player_col(player_col),
    .missile_row(missile_row), .missile_col(missile_col), .missile_busy(missile_busy),
    .player_active(player_active), .player_output(player_output),
    .missile_active(missile_active), .missile_output(missile_output)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_col = 305; m_mrow = 0; m_mcol = 0; m_phase = 0; m_cool_ticks = 0;
    m_pend = 0; m_prev = 0;
  endtask

  task automatic model_clk(input bit ft, input bit bl, input bit br, input bit bf, input bit hit);
    bit pressed;
    pressed = bf && !m_prev;
    m_prev = bf;
    if (m_phase == 0) begin
      if (ft && m_pend) begin
        m_phase = 1; m_mcol = m_col + 15; m_mrow = 422; m_pend = 0;
      end else if (pressed) m_pend = 1;
    end else if (m_phase == 1) begin
      if (hit || (ft && m_mrow < 6)) begin
        m_phase = 2; m_cool_ticks = 0;
      end else if (ft) m_mrow = m_mrow - 6;
    end else if (ft) begin
      m_cool_ticks++;
      if (m_cool_ticks >= 10) m_phase = 0;
    end
    if (ft && bl && !br) m_col = (m_col - 4 < 0) ? 0 : m_col - 4;
    else if (ft && br && !bl) m_col = (m_col + 4 > 609) ? 609 : m_col + 4;
  endtask

  // One clock: drive at negedge, model follows the posedge, return at next negedge
  task automatic step(input bit ft, input bit bl, input bit br, input bit bf, input bit hit);
    frame_tick = ft; btn_left = bl; btn_right = br; btn_fire = bf; missile_hit = hit;
    @(posedge clk);
    model_clk(ft, bl, br, bf, hit);
    @(negedge clk);
  endtask

  task automatic frame(input bit bl, input bit br, input bit bf);
    step(1'b1, bl, br, bf, 1'b0);
    step(1'b0, bl, br, bf, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    frame_tick = 0; btn_left = 0; btn_right = 0; btn_fire = 0; missile_hit = 0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic launch();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    frame(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    model_reset();
    @(negedge clk);
    checks++; if (player_col !== 12'd305) begin failures++; $display("FAIL reset_col got=%0d exp=305", player_col); end
    checks++; if (missile_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", missile_busy); end
    checks++; if (missile_row !== 12'd0 || missile_col !== 12'd0) begin failures++; $display("FAIL reset_missile got=%0d/%0d exp=0/0", missile_row, missile_col); end
    rst = 1'b1;
    pixel_row = 12'd440; pixel_column = 12'd320;
    #1;
    checks++; if (player_output !== 4'hF) begin failures++; $display("FAIL reset_body_pixel got=%h exp=F", player_output); end
    pixel_row = 12'd432; pixel_column = 12'd306;
    #1;
    checks++; if (player_active !== 1'b1) begin failures++; $display("FAIL reset_tip_active got=%b exp=1", player_active); end
    checks++; if (player_output !== 4'h0) begin failures++; $display("FAIL reset_tip_output got=%h exp=0", player_output); end
    pixel_row = 12'd432; pixel_column = 12'd321;
    #1;
    checks++; if (player_output !== 4'hF) begin failures++; $display("FAIL reset_barrel got=%h exp=F", player_output); end
    @(negedge clk);
  endtask

  task automatic test_right_clamp();
    do_reset();
    repeat (76) frame(1'b0, 1'b1, 1'b0);
    checks++; if (player_col !== 12'd609) begin failures++; $display("FAIL right_76 got=%0d exp=609", player_col); end
    repeat (4) frame(1'b0, 1'b1, 1'b0);
    checks++; if (player_col !== 12'd609) begin failures++; $display("FAIL right_80 got=%0d exp=609", player_col); end
    repeat (3) frame(1'b1, 1'b0, 1'b0);
    checks++; if (player_col !== 12'd597) begin failures++; $display("FAIL left_from_edge got=%0d exp=597", player_col); end
    repeat (5) frame(1'b1, 1'b1, 1'b0);
    checks++; if (player_col !== 12'd597) begin failures++; $display("FAIL both_hold got=%0d exp=597", player_col); end
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (player_col !== 12'd597) begin failures++; $display("FAIL no_tick_hold got=%0d exp=597", player_col); end
  endtask

  task automatic test_left_clamp();
    do_reset();
    repeat (76) frame(1'b1, 1'b0, 1'b0);
    checks++; if (player_col !== 12'd1) begin failures++; $display("FAIL left_76 got=%0d exp=1", player_col); end
    frame(1'b1, 1'b0, 1'b0);
    checks++; if (player_col !== 12'd0) begin failures++; $display("FAIL left_77 got=%0d exp=0", player_col); end
    repeat (3) frame(1'b1, 1'b0, 1'b0);
    checks++; if (player_col !== 12'd0) begin failures++; $display("FAIL left_80 got=%0d exp=0", player_col); end
  endtask

  task automatic test_fire_fly();
    do_reset();
    launch();
    checks++; if (missile_row !== 12'd422 || missile_col !== 12'd320 || missile_busy !== 1'b1) begin
      failures++; $display("FAIL launch got=%0d/%0d/%b exp=422/320/1", missile_row, missile_col, missile_busy); end
    pixel_row = 12'd425; pixel_column = 12'd321;
    #1;
    checks++; if (missile_output !== 4'hF) begin failures++; $display("FAIL missile_pixel got=%h exp=F", missile_output); end
    @(negedge clk);
    repeat (70) frame(1'b0, 1'b0, 1'b0);
    checks++; if (missile_row !== 12'd2 || missile_busy !== 1'b1) begin
      failures++; $display("FAIL fly_70 got=%0d/%b exp=2/1", missile_row, missile_busy); end
    frame(1'b0, 1'b0, 1'b0);
    checks++; if (missile_busy !== 1'b0) begin failures++; $display("FAIL exit_top got=%b exp=0", missile_busy); end
    repeat (9) frame(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    frame(1'b0, 1'b0, 1'b0);
    checks++; if (missile_busy !== 1'b0) begin failures++; $display("FAIL cooldown_len got=%b exp=0", missile_busy); end
    launch();
    checks++; if (missile_busy !== 1'b1) begin failures++; $display("FAIL relaunch got=%b exp=1", missile_busy); end
  endtask

  task automatic test_rate_limit();
    do_reset();
    launch();
    repeat (70) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      frame(1'b0, 1'b0, 1'b0);
    end
    frame(1'b0, 1'b0, 1'b0);
    checks++; if (missile_busy !== 1'b0) begin failures++; $display("FAIL rate_exit got=%b exp=0", missile_busy); end
    repeat (9) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      frame(1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) frame(1'b0, 1'b0, 1'b1);
    checks++; if (missile_busy !== 1'b0) begin failures++; $display("FAIL held_no_fire got=%b exp=0", missile_busy); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    launch();
    checks++; if (missile_busy !== 1'b1) begin failures++; $display("FAIL repress_fire got=%b exp=1", missile_busy); end
  endtask

  task automatic test_hit_kill();
    do_reset();
    launch();
    repeat (5) frame(1'b0, 1'b0, 1'b0);
    checks++; if (missile_row !== 12'd392) begin failures++; $display("FAIL hit_pre_row got=%0d exp=392", missile_row); end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (missile_busy !== 1'b0 || missile_row !== 12'd392) begin
      failures++; $display("FAIL hit_kill got=%b/%0d exp=0/392", missile_busy, missile_row); end
    repeat (10) frame(1'b0, 1'b0, 1'b0);
    launch();
    repeat (3) frame(1'b0, 1'b0, 1'b0);
    checks++; if (missile_busy !== 1'b1) begin failures++; $display("FAIL hit_relaunch got=%b exp=1", missile_busy); end
    #2 rst = 1'b0;
    #1;
    checks++; if (missile_busy !== 1'b0 || missile_row !== 12'd0) begin
      failures++; $display("FAIL async_rst got=%b/%0d exp=0/0", missile_busy, missile_row); end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    bit ft, bl, br, bf, hit;
    int r, c;
    bit e_pa, e_ma;
    logic [3:0] e_po;
    bf = 0;
    for (int i = 0; i < 3000; i++) begin
      ft  = ($urandom_range(0, 2) == 0);
      bl  = $urandom_range(0, 1);
      br  = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) bf = !bf;
      hit = ($urandom_range(0, 39) == 0);
      step(ft, bl, br, bf, hit);
      checks++; if (player_col !== 12'(m_col)) begin failures++; $display("FAIL rnd_col i=%0d got=%0d exp=%0d", i, player_col, m_col); end
      checks++; if (missile_busy !== (m_phase == 1)) begin failures++; $display("FAIL rnd_busy i=%0d got=%b exp=%b", i, missile_busy, m_phase == 1); end
      checks++; if (missile_row !== 12'(m_mrow) || missile_col !== 12'(m_mcol)) begin
        failures++; $display("FAIL rnd_missile i=%0d got=%0d/%0d exp=%0d/%0d", i, missile_row, missile_col, m_mrow, m_mcol); end
      if ($urandom_range(0, 1) == 0) begin
        pixel_row    = 12'($urandom_range(428, 453));
        pixel_column = 12'(m_col + $urandom_range(0, 32));
      end else begin
        pixel_row    = 12'(m_mrow + $urandom_range(0, 9) - 1);
        pixel_column = 12'(m_mcol + $urandom_range(0, 3) - 1);
      end
      r = int'(pixel_row);
      c = int'(pixel_column);
      e_pa = (r >= 431) && (r <= 450) && (c >= m_col + 1) && (c <= m_col + 30);
      e_po = (e_pa && (r >= 435 || c == m_col + 15 || c == m_col + 16)) ? 4'hF : 4'h0;
      e_ma = (m_phase == 1) && (r >= m_mrow) && (r <= m_mrow + 7) && (c >= m_mcol) && (c <= m_mcol + 1);
      #1;
      checks++; if (player_active !== e_pa || player_output !== e_po) begin
        failures++; $display("FAIL rnd_player_pix i=%0d rc=%0d,%0d got=%b/%h exp=%b/%h", i, r, c, player_active, player_output, e_pa, e_po); end
      checks++; if (missile_active !== e_ma || missile_output !== (e_ma ? 4'hF : 4'h0)) begin
        failures++; $display("FAIL rnd_missile_pix i=%0d rc=%0d,%0d got=%b/%h exp=%b", i, r, c, missile_active, missile_output, e_ma); end
    end
  endtask

  initial begin
    test_reset();
    test_right_clamp();
    test_left_clamp();
    test_fire_fly();
    test_rate_limit();
    test_hit_kill();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
